// File: rtl/bus_grant_arbiter.sv
// Round-robin bus grant arbiter with registered one-hot grant and R0 BAout.
// Optional tenure limit enabled by defining ARB_TENURE_LIMIT_EN.
module bus_grant_arbiter #(
  parameter int N_REQ      = 8,
  parameter int ID_W       = 4,
  parameter int MAX_TENURE = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_REQ-1:0] req,
  input  logic             ba_mode,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             bus_busy,
  output logic             BAout
);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_nreq
    $error("N_REQ out of range");
  end
  if ((1 << ID_W) < N_REQ) begin : g_bad_idw
    $error("ID_W too narrow");
  end
  if (MAX_TENURE < 1) begin : g_bad_ten
    $error("MAX_TENURE must be >= 1");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_id_nxt;
  logic [ID_W-1:0]  r_last;
  logic [ID_W-1:0]  w_last_nxt;
  logic             r_busy;
  logic             w_busy_nxt;

  logic [N_REQ-1:0] w_cand;
  logic             w_found;
  logic [ID_W-1:0]  w_win;
  logic             w_hold_req;
  logic             w_expire;
  logic             w_load;

  // The holder is masked out so a handover always favours the others.
  assign w_cand     = (r_state == HELD) ? (req & ~r_gnt) : req;
  assign w_hold_req = |(req & r_gnt);

  always_comb begin
    int v_idx;
    w_found = 1'b0;
    w_win   = '0;
    v_idx   = 0;
    for (int i = 0; i < N_REQ; i++) begin
      v_idx = int'(r_last) + 1 + i;
      if (v_idx >= N_REQ) v_idx = v_idx - N_REQ;
      if (!w_found && w_cand[v_idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(v_idx);
      end
    end
  end

`ifdef ARB_TENURE_LIMIT_EN
  localparam int CNT_W = (MAX_TENURE > 1) ? $clog2(MAX_TENURE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_TENURE - 1);

  logic [CNT_W-1:0] r_cnt;

  // In HELD, w_found already means some other source is waiting.
  assign w_expire = (r_state == HELD) && (r_cnt == CNT_MAX) && w_found;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (r_state == HELD && r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_id;
    w_busy_nxt  = r_busy;
    w_last_nxt  = r_last;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) w_load = 1'b1;
      end
      HELD: begin
        if (!w_hold_req || w_expire) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_id_nxt    = '0;
            w_busy_nxt  = 1'b0;
          end
        end
      end
    endcase
    if (w_load) begin
      w_state_nxt = HELD;
      w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
      w_id_nxt    = w_win;
      w_busy_nxt  = 1'b1;
      w_last_nxt  = w_win;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_busy  <= 1'b0;
      r_last  <= ID_W'(N_REQ - 1);
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_id    <= w_id_nxt;
      r_busy  <= w_busy_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign gnt      = r_gnt;
  assign gnt_id   = r_id;
  assign bus_busy = r_busy;
  assign BAout    = r_gnt[0] & ba_mode;

endmodule

// File: tb/tb_bus_grant_arbiter.sv
// Randomized bench for bus_grant_arbiter against a behavioural model.
// Honors ARB_TENURE_LIMIT_EN the same way the design does.
module tb_bus_grant_arbiter;

  localparam int N   = 8;
  localparam int MXT = 4;

  logic         clock;
  logic         clear;
  logic [N-1:0] req;
  logic         ba_mode;
  logic [N-1:0] gnt;
  logic [3:0]   gnt_id;
  logic         bus_busy;
  logic         BAout;

  int n_chk;
  int n_err;

  int m_holder;
  int m_last;
  int m_held;

  bus_grant_arbiter #(
    .N_REQ(N),
    .ID_W(4),
    .MAX_TENURE(MXT)
  ) dut (
    .clock(clock),
    .clear(clear),
    .req(req),
    .ba_mode(ba_mode),
    .gnt(gnt),
    .gnt_id(gnt_id),
    .bus_busy(bus_busy),
    .BAout(BAout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start,
                              input int excl);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (start + i) % N;
      if (idx != excl && r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_holder = -1;
    m_last   = N - 1;
    m_held   = 0;
  endtask

  task automatic model_edge();
    int w;
    bit drop;
    bit frc;
    if (m_holder < 0) begin
      w = pick(req, (m_last + 1) % N, -1);
      if (w >= 0) begin
        m_holder = w;
        m_last   = w;
        m_held   = 0;
      end
    end else begin
      drop = !req[m_holder];
      frc  = 1'b0;
`ifdef ARB_TENURE_LIMIT_EN
      frc = (m_held >= MXT - 1) &&
            ((req & ~(8'b1 << m_holder)) != 0);
`endif
      if (drop || frc) begin
        w = pick(req, m_holder + 1, m_holder);
        if (w >= 0) begin
          m_holder = w;
          m_last   = w;
          m_held   = 0;
        end else begin
          m_holder = -1;
        end
      end else begin
        m_held++;
      end
    end
  endtask

  task automatic check_outs(input string tag);
    logic [N-1:0] eg;
    eg = (m_holder >= 0) ? (8'b1 << m_holder) : 8'h00;
    check({tag, "_gnt"}, gnt, eg);
    check({tag, "_id"}, gnt_id, (m_holder >= 0) ? m_holder : 0);
    check({tag, "_busy"}, bus_busy, m_holder >= 0);
    check({tag, "_ba"}, BAout, (m_holder == 0) && ba_mode);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    if (clear) model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic pulse_clear(input string tag);
    clear = 1'b0;
    model_reset();
    #1;
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_busy"}, bus_busy, 0);
    check_outs(tag);
    #2;
    clear = 1'b1;
  endtask

  int rr_exp[4] = '{0, 2, 5, 0};

  initial begin
    n_chk   = 0;
    n_err   = 0;
    clock   = 1'b0;
    clear   = 1'b0;
    req     = 8'hFF;
    ba_mode = 1'b1;
    model_reset();

    #12;
    check("rst_gnt", gnt, 0);
    check("rst_id", gnt_id, 0);
    check("rst_busy", bus_busy, 0);
    check("rst_ba", BAout, 0);
    #1;
    clear = 1'b1;
    step("first");
    check("first_gnt", gnt, 8'h01);
    check("first_id", gnt_id, 0);

    req = 8'h00;
    pulse_clear("clr_rr");
    for (int k = 0; k < 4; k++) begin
      req = 8'h25 & ~((m_holder >= 0) ? (8'b1 << m_holder) : 8'h00);
      step("rr");
      check("rr_order", gnt_id, rr_exp[k]);
      check("rr_busy_on", bus_busy, 1);
    end

    req = 8'h00;
    step("rr_end");
    step("idle");
    req = 8'h08;
    for (int k = 0; k < 3; k++) begin
      step("single");
      check("single_gnt", gnt, 8'h08);
      check("single_id", gnt_id, 3);
    end
    req = 8'h00;
    step("single_off");
    check("single_off_gnt", gnt, 0);

    ba_mode = 1'b1;
    req     = 8'h01;
    step("ba");
    check("ba_on", BAout, 1);
    ba_mode = 1'b0;
    #1;
    check("ba_toggle", BAout, 0);
    check_outs("ba_tog");
    ba_mode = 1'b1;
    req     = 8'h10;
    step("ba_mv");
    check("ba_moved_id", gnt_id, 4);
    check("ba_moved", BAout, 0);

    req = 8'h00;
    pulse_clear("clr_ten");
    req = 8'h03;
    for (int k = 0; k < 12; k++) begin
      step("ten");
`ifdef ARB_TENURE_LIMIT_EN
      check("ten_pat", gnt, ((k / 4) % 2 == 0) ? 8'h01 : 8'h02);
`else
      check("ten_pat", gnt, 8'h01);
`endif
    end

    req = 8'h10;
    step("mid_a");
    step("mid_b");
    check("mid_held", gnt, 8'h10);
    pulse_clear("mid_clr");
    check("mid_zero", gnt, 0);
    req = 8'h11;
    step("mid_after");
    check("mid_ptr", gnt, 8'h01);

    for (int k = 0; k < 3000; k++) begin
      req     = N'($urandom);
      if ($urandom_range(0, 2) == 0) req = req & N'($urandom);
      ba_mode = 1'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_clear("rnd_clr");
      step("rnd");
      if ($urandom_range(0, 9) == 0) begin
        ba_mode = ~ba_mode;
        #1;
        check_outs("rnd_ba");
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
